// File: rtl/led_ctrl_multi.sv
// rtl/led_ctrl_multi.sv - halfstrip hit LED controller with flash stretching and cylon status
module led_ctrl_multi #(
  parameter int NHS         = 32,
  parameter int HS_PER_DS   = 4,
  parameter int STRETCH_W   = 24,
  parameter int GAP_LEN     = 2000000,
  parameter int CYLON_DIV_W = 22,
  localparam int NDS        = NHS / HS_PER_DS,
  localparam int NLED       = NDS + HS_PER_DS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 dcms_locked,
  input  logic                 pulser_ready,
  input  logic [1:0]           mode,
  input  logic [STRETCH_W-1:0] stretch_len,
  input  logic [NHS-1:0]       halfstrips,
  input  logic                 clear_seen,
  output logic [NLED-1:0]      leds,
  output logic                 seen_hit
);

  localparam int GAP_W = $clog2(GAP_LEN + 1);
  localparam int CNT_W = (STRETCH_W > GAP_W) ? STRETCH_W : GAP_W;
  localparam int POS_W = $clog2(NDS);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } state_t;

  // Stage 1: distrip groups and side positions
  logic [NDS-1:0]       ds_d, ds_q;
  logic [HS_PER_DS-1:0] sd_d, sd_q;
  logic [NLED-1:0]      trig;

  always_comb begin
    ds_d = '0;
    sd_d = '0;
    for (int g = 0; g < NDS; g++) begin
      ds_d[g] = |halfstrips[g*HS_PER_DS +: HS_PER_DS];
      sd_d    = sd_d | halfstrips[g*HS_PER_DS +: HS_PER_DS];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ds_q <= '0;
      sd_q <= '0;
    end else begin
      ds_q <= ds_d;
      sd_q <= sd_d;
    end
  end

  assign trig = {sd_q, ds_q};

  // Stage 2: per-channel flash FSMs
  logic [STRETCH_W-1:0] stretch_m1;
  logic [CNT_W-1:0]     stretch_load;

  assign stretch_m1   = (stretch_len == '0) ? '0 : stretch_len - 1'b1;
  assign stretch_load = CNT_W'(stretch_m1);

  state_t           state_q [NLED];
  state_t           state_d [NLED];
  logic [CNT_W-1:0] cnt_q   [NLED];
  logic [CNT_W-1:0] cnt_d   [NLED];
  logic [NLED-1:0]  pend_q, pend_d;
  logic [NLED-1:0]  lit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NLED; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NLED; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    lit    = '0;
    for (int i = 0; i < NLED; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trig[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = stretch_load;
          end
        end
        ST_ON: begin
          lit[i] = 1'b1;
          if (trig[i]) pend_d[i] = 1'b1;
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_GAP;
            cnt_d[i]   = GAP_LOAD;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_GAP: begin
          if (trig[i]) pend_d[i] = 1'b1;
          if (cnt_q[i] == '0) begin
            // a hit landing on the last dark cycle still queues a new flash
            if (pend_q[i] || trig[i]) begin
              pend_d[i]  = 1'b0;
              state_d[i] = ST_ON;
              cnt_d[i]   = stretch_load;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Cylon generator: free-running prescaler, bouncing position
  logic [CYLON_DIV_W-1:0] presc_q;
  logic [POS_W-1:0]       pos_q;
  logic                   dir_down_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q    <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) begin
        if (!dir_down_q) begin
          pos_q <= pos_q + 1'b1;
          if (pos_q == POS_W'(NDS - 2)) dir_down_q <= 1'b1;
        end else begin
          pos_q <= pos_q - 1'b1;
          if (pos_q == POS_W'(1)) dir_down_q <= 1'b0;
        end
      end
    end
  end

  logic [POS_W-1:0] pos_mirror;
  logic [NLED-1:0]  cyl_a, cyl_b;

  assign pos_mirror = POS_W'(NDS - 1) - pos_q;
  assign cyl_a      = NLED'(1) << pos_q;
  assign cyl_b      = cyl_a | (NLED'(1) << pos_mirror);

  // Stage 3: registered output mux
  logic [NLED-1:0] leds_d;

  always_comb begin
    leds_d = lit;
    case (mode)
      2'd0: begin
        if (!dcms_locked)      leds_d = cyl_b;
        else if (pulser_ready) leds_d = cyl_a;
        else                   leds_d = lit;
      end
      2'd1:    leds_d = lit;
      2'd2:    leds_d = cyl_a;
      default: leds_d = '1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      leds     <= '0;
      seen_hit <= 1'b0;
    end else begin
      leds <= leds_d;
      if (|trig)           seen_hit <= 1'b1;
      else if (clear_seen) seen_hit <= 1'b0;
    end
  end

endmodule

// File: doc/led_ctrl_multi.md
Name: led_ctrl_multi

Overview:
- Parametrised successor LED front-panel controller for the comparator test board.
- Reduces NHS halfstrip hit lines into distrip-group LEDs and side (halfstrip-position-within-group) LEDs.
- Stretches each hit into a visible flash with a guaranteed dark gap and queued retrigger.
- Shows cylon status patterns while clocks are unlocked or the pulser is idle-ready, with a software mode override and lamp test.

Parameters:
- NHS, 32: halfstrip input count; must be a multiple of HS_PER_DS.
- HS_PER_DS, 4: halfstrips per distrip group. This is also the number of side LEDs.
- NDS, NHS/HS_PER_DS: distrip LEDs (derived; must be >= 2).
- NLED, NDS+HS_PER_DS: total LEDs (derived).
- STRETCH_W, 24: width of the stretch_len input.
- GAP_LEN, 2000000: forced-dark cycles after each flash (>= 1).
- CYLON_DIV_W, 22: cylon prescaler width. The cylon steps once every 2^CYLON_DIV_W cycles.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: synchronous, active-low reset.
- dcms_locked, in, 1: clock managers locked.
- pulser_ready, in, 1: pulser armed and waiting.
- mode, in, 2: 0 = auto, 1 = force hits, 2 = force cylon, 3 = lamp test.
- stretch_len, in, STRETCH_W: flash on-time in cycles. A value of 0 is treated as 1.
- halfstrips, in, NHS: halfstrip hit lines, synchronous to clock.
- clear_seen, in, 1: clears the seen_hit flag.
- leds, out, NLED: [NDS-1:0] = distrip LEDs, [NLED-1:NDS] = side LEDs.
- seen_hit, out, 1: sticky "any hit since reset/clear".

Behaviour:
- Reset (reset_n low at a clock edge):
  - leds = 0, seen_hit = 0.
  - All flash FSMs to IDLE with pending cleared.
  - Prescaler = 0, cylon position = 0, direction = up.
  - Reset wins over every other input in the same cycle.
- Stage 1 (registered reduction):
  - ds[g] = OR of halfstrips[g*HS_PER_DS +: HS_PER_DS].
  - sd[s] = OR of halfstrips[s + k*HS_PER_DS] for k = 0..NDS-1.
- Stage 2: one flash FSM per LED channel (NLED channels), driven by that channel's stage-1 bit.
  - IDLE:
    - Trigger high: load cnt = max(stretch_len,1) - 1, go to ON.
  - ON:
    - Channel is lit.
    - A trigger sets pending.
    - cnt == 0: load cnt = GAP_LEN - 1, go to GAP.
    - Otherwise: cnt decrements.
  - GAP:
    - Channel is dark.
    - A trigger sets pending.
    - cnt == 0: if pending, or trigger high this cycle, clear pending, reload the stretch count and go to ON. Otherwise go to IDLE.
    - Otherwise: cnt decrements.
  - stretch_len is sampled only on entry to ON. Changes mid-flash do not affect the current flash.
- Stage 3: registered output mux.
  - mode 0: !dcms_locked selects cylon B. Else pulser_ready selects cylon A. Else hit display.
  - mode 1: hit display.
  - mode 2: cylon A.
  - mode 3: all NLED bits set.
  - Hit display: leds[i] = channel i lit.
  - Cylon A: only distrip LED pos is set.
  - Cylon B: distrip LEDs pos and NDS-1-pos are set.
  - In both cylon patterns the side LEDs are 0.
- Latency: a halfstrip high before edge N gives ds/sd at N, FSM ON at N+1, and leds high after edge N+2.
- Flash width: the LED stays lit for exactly max(stretch_len,1) consecutive cycles.
- Cylon generator:
  - The prescaler is free-running, is not gated by mode, and wraps modulo 2^CYLON_DIV_W.
  - On wrap to 0: if direction is up, pos increments; at pos = NDS-1 the direction flips to down. The mirror rule applies at pos = 0.
  - Sequence with NDS = 4: 0,1,2,3,2,1,0,1 ...
- seen_hit:
  - Set the cycle after any stage-1 bit is high.
  - clear_seen clears it.
  - If a set and clear_seen occur in the same cycle, set wins.
- The FSMs keep running in cylon and lamp-test modes. Returning to hit display immediately shows the current FSM state.

Test Plan:
- Reset: hold reset_n = 0 with random inputs for 5 cycles -> leds = 0, seen_hit = 0. Release with mode = 1 and no hits -> leds stay 0.
- Single hit: mode = 1, stretch_len = 10, GAP_LEN = 4, halfstrips = 0x0000_0020 for 1 cycle -> leds[1] and leds[9] (side 1) high for exactly 10 cycles, starting 3 edges after the hit. seen_hit goes to 1.
- Retrigger: same setup, second pulse during ON -> 10 on, exactly 4 dark, then 10 on again. A hit during the final GAP cycle also retriggers.
- stretch_len = 0: pulse on halfstrips[31] -> leds[7] and leds[11] lit for 1 cycle.
- Mode priority: mode = 0, CYLON_DIV_W = 2, NDS = 8:
  - dcms_locked = 0 -> mirrored pair 0x81, 0x42, 0x24 ... stepping every 4 cycles.
  - Lock with pulser_ready = 1 -> single walker 0x01, 0x02, ... bounces at 0x80.
  - mode = 3 -> leds = 0xFFF.
- clear_seen: clear_seen coincident with a new hit -> seen_hit stays 1. clear_seen alone -> seen_hit drops to 0 next cycle.
